frame_former_buffer: RTL

FRAME_FORMER_BUFFER -- requirements
Module: frame_former_buffer

---
 rtl/frame_former_buffer_if.sv | 28 ++
 rtl/frame_former_buffer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/frame_former_buffer_if.sv
// AXI-Stream style beat bus shared by the upstream and downstream sides of
// the frame former buffer. The master drives the beat, the slave drives
// tready back.
interface frame_former_buffer_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/frame_former_buffer.sv
// Frame former buffer: first-word-fall-through circular buffer for
// AXI-Stream beats. It tracks the occupancy in beats (FFSTail) and the
// number of complete frames held (FrameCount). The downstream stage uses
// these counts to decide when a frame may be released.
//
// S_AXIS.tready depends only on registered state, so no combinational path
// runs from M_AXIS.tready through the buffer. As a result, a pop on a full
// buffer cannot admit a push in the same cycle.
module frame_former_buffer #(
    parameter  int MAX_INTERNAL_SPACE = 64,
    parameter  int DATA_WIDTH         = 64,
    localparam int PTR_W              = $clog2(MAX_INTERNAL_SPACE),
    localparam int CNT_W              = PTR_W + 1
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    frame_former_buffer_if.slave        S_AXIS,
    frame_former_buffer_if.master       M_AXIS,
    output logic [CNT_W-1:0]            FFSTail,
    output logic [CNT_W-1:0]            FrameCount
);

    localparam int                KEEP_W   = DATA_WIDTH / 8;
    localparam int                ENTRY_W  = DATA_WIDTH + KEEP_W + 1;
    localparam logic [CNT_W-1:0]  FULL_LVL = CNT_W'(MAX_INTERNAL_SPACE);

    // Reject parameterisations the pointer arithmetic cannot support.
    // Pointer wrap relies on natural overflow of a power-of-two depth.
    if (MAX_INTERNAL_SPACE < 2 ||
        (MAX_INTERNAL_SPACE & (MAX_INTERNAL_SPACE - 1)) != 0) begin : g_bad_depth
        $error("frame_former_buffer: MAX_INTERNAL_SPACE must be a power of two >= 2");
    end
    if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("frame_former_buffer: DATA_WIDTH must be a non-zero multiple of 8");
    end

    // Storage holds {tlast, tkeep, tdata}. It is deliberately not reset.
    logic [ENTRY_W-1:0] r_mem [MAX_INTERNAL_SPACE];

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_frames;
    // Holds tready low for the cycles in which reset was sampled, so the
    // upstream side does not see the buffer as ready during reset.
    logic               r_in_reset;

    logic               w_push;
    logic               w_pop;
    logic               w_push_last;
    logic               w_pop_last;
    logic               w_full;
    logic               w_empty;
    logic [ENTRY_W-1:0] w_wr_entry;
    logic [ENTRY_W-1:0] w_head;

    assign w_full      = (r_count == FULL_LVL);
    assign w_empty     = (r_count == '0);

    assign S_AXIS.tready = !r_in_reset && !w_full;
    assign M_AXIS.tvalid = !w_empty;

    assign w_push      = S_AXIS.tvalid & S_AXIS.tready;
    assign w_pop       = M_AXIS.tvalid & M_AXIS.tready;

    assign w_wr_entry  = {S_AXIS.tlast, S_AXIS.tkeep, S_AXIS.tdata};
    assign w_head      = r_mem[r_rd_ptr];

    // The head entry falls through to the outputs. It stays stable until it
    // is popped, because only a pop moves the read pointer.
    assign {M_AXIS.tlast, M_AXIS.tkeep, M_AXIS.tdata} = w_head;

    assign w_push_last = w_push & S_AXIS.tlast;
    assign w_pop_last  = w_pop  & w_head[ENTRY_W-1];

    assign FFSTail     = r_count;
    assign FrameCount  = r_frames;

    // Write an accepted beat into the slot at the write pointer.
    always_ff @(posedge ACLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // Track whether reset was sampled at the last edge (gates tready).
    always_ff @(posedge ACLK) begin
        r_in_reset <= ARESET;
    end

    // Advance the write pointer on each push. Modulo-depth wrap is implicit.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
        end
    end

    // Advance the read pointer on each pop. Modulo-depth wrap is implicit.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Occupancy: +1 on push only, -1 on pop only, otherwise held.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Complete-frame count: follows tlast beats entering and leaving.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_frames <= '0;
        end else begin
            case ({w_push_last, w_pop_last})
                2'b10:   r_frames <= r_frames + 1'b1;
                2'b01:   r_frames <= r_frames - 1'b1;
                default: r_frames <= r_frames;
            endcase
        end
    end

    // Structural invariants of the counters.
    a_count_range: assert property (@(posedge ACLK) disable iff (ARESET)
        r_count <= FULL_LVL);
    a_frames_le_count: assert property (@(posedge ACLK) disable iff (ARESET)
        r_frames <= r_count);

endmodule
